// File: rtl/mem_refill_responder.sv
// mem_refill_responder
//
// Memory-side responder for the cache-refill protocol. It sits between the
// refill crossbar and a synchronous backing SRAM.
//
// Tagged requests are accepted into a small FIFO and served strictly in order,
// one at a time:
//   - An in-range read waits LATENCY cycles. It then streams REFILL_BEATS SRAM
//     reads, and each returned beat carries the request tag.
//   - An in-range write gets a single-cycle ack (val=1, data=0).
//   - Any request with addr >= MEM_LINES gets a single-cycle nack.
// Responses have no backpressure.
//
// Ports:
//   clk, reset      clock, asynchronous active-low reset
//   mem_req_*       request channel (val/rdy handshake; rw, addr, tag)
//   mem_resp_*      response channel (val, nack, tag, data)
//   sram_rd_*       SRAM read port; data returns the cycle after sram_rd_en
//
// REFILL_BEATS and QDEPTH must be powers of two, both >= 2.

`ifndef MEM_ADDR_BITS
`define MEM_ADDR_BITS 8
`endif
`ifndef MEM_TAG_BITS
`define MEM_TAG_BITS 8
`endif

module mem_refill_responder #(
    parameter int unsigned ADDR_BITS    = `MEM_ADDR_BITS,
    parameter int unsigned TAG_BITS     = `MEM_TAG_BITS,
    parameter int unsigned DATA_BITS    = 128,
    parameter int unsigned QDEPTH       = 4,
    parameter int unsigned LATENCY      = 4,
    parameter int unsigned REFILL_BEATS = 4,
    parameter int unsigned MEM_LINES    = 2 ** ADDR_BITS
) (
    input  logic                                      clk,
    input  logic                                      reset,
    input  logic                                      mem_req_val,
    output logic                                      mem_req_rdy,
    input  logic                                      mem_req_rw,
    input  logic [ADDR_BITS-1:0]                      mem_req_addr,
    input  logic [TAG_BITS-1:0]                       mem_req_tag,
    output logic                                      mem_resp_val,
    output logic                                      mem_resp_nack,
    output logic [TAG_BITS-1:0]                       mem_resp_tag,
    output logic [DATA_BITS-1:0]                      mem_resp_data,
    output logic                                      sram_rd_en,
    output logic [ADDR_BITS+$clog2(REFILL_BEATS)-1:0] sram_rd_addr,
    input  logic [DATA_BITS-1:0]                      sram_rd_data
);

    localparam int unsigned PTR_W  = $clog2(QDEPTH);
    localparam int unsigned CNT_W  = $clog2(QDEPTH) + 1;
    localparam int unsigned BEAT_W = $clog2(REFILL_BEATS);
    localparam int unsigned LAT_W  = $clog2(LATENCY) + 1;

    // One extra bit so that MEM_LINES == 2**ADDR_BITS can be represented.
    localparam logic [ADDR_BITS:0] LINES_LIM = (ADDR_BITS + 1)'(MEM_LINES);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_DELAY  = 2'd1;
    localparam logic [1:0] ST_STREAM = 2'd2;
    localparam logic [1:0] ST_RESP   = 2'd3;

    // ------------------------------------------------------------------
    // Request queue
    // ------------------------------------------------------------------
    logic                 q_rw   [QDEPTH];
    logic [ADDR_BITS-1:0] q_addr [QDEPTH];
    logic [TAG_BITS-1:0]  q_tag  [QDEPTH];

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    // Holds rdy low until the first clock edge after reset release.
    logic live_q;

    logic push;
    logic pop;

    logic [1:0] state_q, state_d;

    assign mem_req_rdy = live_q && (count_q < CNT_W'(QDEPTH));
    assign push        = mem_req_val && mem_req_rdy;
    assign pop         = (state_q == ST_IDLE) && (count_q != '0);

    // Storage needs no reset; the pointers and count define what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            q_rw[wr_ptr_q]   <= mem_req_rw;
            q_addr[wr_ptr_q] <= mem_req_addr;
            q_tag[wr_ptr_q]  <= mem_req_tag;
        end
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        // Pointers are PTR_W bits wide, so they wrap modulo QDEPTH.
        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        unique case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            live_q   <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            live_q   <= 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Service FSM
    // ------------------------------------------------------------------
    logic                 head_rw;
    logic [ADDR_BITS-1:0] head_addr;
    logic [TAG_BITS-1:0]  head_tag;
    logic                 head_oor;

    assign head_rw   = q_rw[rd_ptr_q];
    assign head_addr = q_addr[rd_ptr_q];
    assign head_tag  = q_tag[rd_ptr_q];
    assign head_oor  = {1'b0, head_addr} >= LINES_LIM;

    logic [LAT_W-1:0]     cnt_q, cnt_d;
    logic [BEAT_W-1:0]    beat_q, beat_d;
    logic [ADDR_BITS-1:0] cur_addr_q, cur_addr_d;
    logic [TAG_BITS-1:0]  cur_tag_q, cur_tag_d;
    logic                 cur_oor_q, cur_oor_d;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        beat_d     = beat_q;
        cur_addr_d = cur_addr_q;
        cur_tag_d  = cur_tag_q;
        cur_oor_d  = cur_oor_q;
        unique case (state_q)
            ST_IDLE: begin
                if (pop) begin
                    cur_addr_d = head_addr;
                    cur_tag_d  = head_tag;
                    cur_oor_d  = head_oor;
                    if (head_oor || head_rw) begin
                        state_d = ST_RESP;
                    end else begin
                        state_d = ST_DELAY;
                        cnt_d   = LAT_W'(LATENCY - 1);
                    end
                end
            end
            ST_DELAY: begin
                if (cnt_q == '0) begin
                    state_d = ST_STREAM;
                    beat_d  = '0;
                end else begin
                    cnt_d = cnt_q - LAT_W'(1);
                end
            end
            ST_STREAM: begin
                // The beat index wraps naturally to 0 after the last beat.
                beat_d = beat_q + BEAT_W'(1);
                if (beat_q == BEAT_W'(REFILL_BEATS - 1)) begin
                    state_d = ST_IDLE;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            beat_q     <= '0;
            cur_addr_q <= '0;
            cur_tag_q  <= '0;
            cur_oor_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            beat_q     <= beat_d;
            cur_addr_q <= cur_addr_d;
            cur_tag_q  <= cur_tag_d;
            cur_oor_q  <= cur_oor_d;
        end
    end

    assign sram_rd_en   = (state_q == ST_STREAM);
    assign sram_rd_addr = {cur_addr_q, beat_q};

    // ------------------------------------------------------------------
    // Response path
    // ------------------------------------------------------------------
    // The SRAM data is valid the cycle after sram_rd_en. rd_pend_q marks that
    // cycle so the beat can be registered onto the response port. The tag
    // travels with it, so the FSM may already have moved on.
    logic                rd_pend_q;
    logic [TAG_BITS-1:0] pend_tag_q;

    logic                 resp_val_q, resp_val_d;
    logic                 resp_nack_q, resp_nack_d;
    logic [TAG_BITS-1:0]  resp_tag_q, resp_tag_d;
    logic [DATA_BITS-1:0] resp_data_q, resp_data_d;

    always_comb begin
        resp_val_d  = 1'b0;
        resp_nack_d = 1'b0;
        resp_data_d = '0;
        resp_tag_d  = resp_tag_q;
        // A RESP cycle never coincides with a pending beat: an IDLE cycle
        // always separates STREAM from RESP.
        if (rd_pend_q) begin
            resp_val_d  = 1'b1;
            resp_data_d = sram_rd_data;
            resp_tag_d  = pend_tag_q;
        end else if (state_q == ST_RESP) begin
            resp_tag_d = cur_tag_q;
            if (cur_oor_q) begin
                resp_nack_d = 1'b1;
            end else begin
                resp_val_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_pend_q   <= 1'b0;
            pend_tag_q  <= '0;
            resp_val_q  <= 1'b0;
            resp_nack_q <= 1'b0;
            resp_tag_q  <= '0;
            resp_data_q <= '0;
        end else begin
            rd_pend_q   <= sram_rd_en;
            pend_tag_q  <= cur_tag_q;
            resp_val_q  <= resp_val_d;
            resp_nack_q <= resp_nack_d;
            resp_tag_q  <= resp_tag_d;
            resp_data_q <= resp_data_d;
        end
    end

    assign mem_resp_val  = resp_val_q;
    assign mem_resp_nack = resp_nack_q;
    assign mem_resp_tag  = resp_tag_q;
    assign mem_resp_data = resp_data_q;

endmodule

// File: tb/tb_mem_refill_responder.sv
module tb_mem_refill_responder;

    localparam int unsigned AB    = 8;
    localparam int unsigned TW    = 8;
    localparam int unsigned DW    = 128;
    localparam int unsigned QD    = 4;
    localparam int unsigned LAT   = 4;
    localparam int unsigned RB    = 4;
    localparam int unsigned LINES = 200;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          mem_req_val = 1'b0;
    logic          mem_req_rdy;
    logic          mem_req_rw = 1'b0;
    logic [AB-1:0] mem_req_addr = '0;
    logic [TW-1:0] mem_req_tag = '0;
    logic          mem_resp_val;
    logic          mem_resp_nack;
    logic [TW-1:0] mem_resp_tag;
    logic [DW-1:0] mem_resp_data;
    logic          sram_rd_en;
    logic [AB+1:0] sram_rd_addr;
    logic [DW-1:0] sram_rd_data = '0;

    always #5 clk = ~clk;

    mem_refill_responder #(
        .ADDR_BITS   (AB),
        .TAG_BITS    (TW),
        .DATA_BITS   (DW),
        .QDEPTH      (QD),
        .LATENCY     (LAT),
        .REFILL_BEATS(RB),
        .MEM_LINES   (LINES)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .mem_req_val  (mem_req_val),
        .mem_req_rdy  (mem_req_rdy),
        .mem_req_rw   (mem_req_rw),
        .mem_req_addr (mem_req_addr),
        .mem_req_tag  (mem_req_tag),
        .mem_resp_val (mem_resp_val),
        .mem_resp_nack(mem_resp_nack),
        .mem_resp_tag (mem_resp_tag),
        .mem_resp_data(mem_resp_data),
        .sram_rd_en   (sram_rd_en),
        .sram_rd_addr (sram_rd_addr),
        .sram_rd_data (sram_rd_data)
    );

    // Address-derived SRAM contents, so each beat is distinguishable.
    function automatic logic [DW-1:0] mem_word(input logic [AB+1:0] a);
        return {32'hC0DE_0000 + 32'(a), ~32'(a), 32'(a) * 32'd3, 32'(a)};
    endfunction

    always @(posedge clk) begin
        if (sram_rd_en) sram_rd_data <= mem_word(sram_rd_addr);
    end

    typedef struct {
        logic          val;
        logic          nack;
        logic [TW-1:0] tag;
        logic [DW-1:0] data;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail = 0;
    int   rd_en_seen = 0;
    int   rd_en_exp = 0;
    int   last_wait = 0;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents a response.
    always @(negedge clk) begin
        if (reset) begin
            if (sram_rd_en) rd_en_seen++;
            if (mem_resp_val || mem_resp_nack) begin
                check("val_nack_exclusive", DW'(mem_resp_val & mem_resp_nack), '0);
                if (sb.size() == 0) begin
                    check("unexpected_response", DW'({mem_resp_val, mem_resp_nack}), '0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("resp_val", DW'(mem_resp_val), DW'(e.val));
                    check("resp_nack", DW'(mem_resp_nack), DW'(e.nack));
                    check("resp_tag", DW'(mem_resp_tag), DW'(e.tag));
                    check("resp_data", mem_resp_data, e.data);
                end
            end
        end
    end

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic send(input logic rw, input logic [AB-1:0] addr, input logic [TW-1:0] tag);
        int waits = 0;
        mem_req_val  = 1'b1;
        mem_req_rw   = rw;
        mem_req_addr = addr;
        mem_req_tag  = tag;
        while (!mem_req_rdy && waits < 300) begin
            @(negedge clk);
            waits++;
        end
        last_wait = waits;
        if (!mem_req_rdy) begin
            check("req_accept_timeout", DW'(mem_req_rdy), DW'(1));
            mem_req_val = 1'b0;
            return;
        end
        if (32'(addr) >= LINES) begin
            sb.push_back('{1'b0, 1'b1, tag, '0});
        end else if (rw) begin
            sb.push_back('{1'b1, 1'b0, tag, '0});
        end else begin
            for (int b = 0; b < RB; b++) sb.push_back('{1'b1, 1'b0, tag, mem_word({addr, 2'(b)})});
            rd_en_exp += RB;
        end
        @(negedge clk);
        mem_req_val = 1'b0;
    endtask

    task automatic wait_resp(input logic want_nack, output int n);
        n = 0;
        while (!(want_nack ? mem_resp_nack : mem_resp_val) && n < 60) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        while (sb.size() != 0 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        repeat (3) @(negedge clk);
        check("scoreboard_drained", DW'(sb.size()), '0);
    endtask

    logic          wr_rw   [12] = '{0, 1, 0, 0, 1, 0, 1, 0, 0, 1, 0, 0};
    logic [AB-1:0] wr_addr [12] = '{8'h02, 8'h40, 8'hC8, 8'h7F, 8'hFF, 8'h00,
                                    8'h11, 8'hC7, 8'hC9, 8'h22, 8'h55, 8'h63};

    initial begin
        int n;
        #2 reset = 1'b0;
        #10;
        check("reset_rdy", DW'(mem_req_rdy), '0);
        check("reset_outputs", DW'({mem_resp_val, mem_resp_nack, sram_rd_en}), '0);
        check("reset_tag", DW'(mem_resp_tag), '0);
        check("reset_data", mem_resp_data, '0);
        #10 reset = 1'b1;                     // released at t=22, between edges
        #1 check("rdy_before_first_edge", DW'(mem_req_rdy), '0);
        @(negedge clk);
        check("rdy_after_release", DW'(mem_req_rdy), DW'(1));

        // Single read: first beat 7 cycles after acceptance, 4 contiguous beats.
        send(1'b0, 8'h10, 8'h05);
        wait_resp(1'b0, n);
        check("read_latency", DW'(n), DW'(7));
        for (int i = 0; i < RB; i++) begin
            check("beat_contiguous", DW'(mem_resp_val), DW'(1));
            @(negedge clk);
        end
        check("val_low_after_refill", DW'(mem_resp_val), '0);
        wait_idle();

        // Write ack, then out-of-range read nack; neither touches the SRAM.
        n = rd_en_seen;
        send(1'b1, 8'h33, 8'h21);
        begin
            int m;
            wait_resp(1'b0, m);
            check("write_ack_latency", DW'(m), DW'(2));
            @(negedge clk);
            send(1'b0, 8'(LINES), 8'h22);
            wait_resp(1'b1, m);
            check("nack_latency", DW'(m), DW'(2));
        end
        wait_idle();
        check("no_sram_for_write_nack", DW'(rd_en_seen), DW'(n));

        // Reset in the middle of a refill.
        send(1'b0, 8'h20, 8'h40);
        wait_resp(1'b0, n);
        @(negedge clk);
        #2 reset = 1'b0;
        #1;
        check("midreset_outputs", DW'({mem_resp_val, mem_resp_nack, sram_rd_en, mem_req_rdy}), '0);
        check("midreset_tag", DW'(mem_resp_tag), '0);
        check("midreset_data", mem_resp_data, '0);
        sb.delete();
        rd_en_exp = 0;
        rd_en_seen = 0;
        @(negedge clk);
        #2 reset = 1'b1;
        #1 check("midreset_rdy_low", DW'(mem_req_rdy), '0);
        @(negedge clk);
        check("midreset_rdy_high", DW'(mem_req_rdy), DW'(1));
        repeat (20) @(negedge clk);         // any stale beat is flagged by the monitor

        // Fill to full behind a busy read.
        send(1'b0, 8'h01, 8'h30);
        for (int t = 1; t <= 5; t++) begin
            send(1'b0, 8'(t * 3), 8'(t));
            if (t == 4) check("full_rdy_low", DW'(mem_req_rdy), '0);
            if (t == 5) check("fifth_waited_for_pop", DW'(last_wait != 0), DW'(1));
        end
        wait_idle();

        // Mixed traffic with random gaps; pointers wrap several times.
        for (int i = 0; i < 12; i++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            send(wr_rw[i], wr_addr[i], 8'(8'h50 + i));
        end
        wait_idle();
        check("sram_rd_en_count", DW'(rd_en_seen), DW'(rd_en_exp));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
